// File: rtl/hdr_pkg.sv
// Shared types for the HDR command descriptor fetch path.
// Holds the FSM state encoding, descriptor layout and mode constants.
package hdr_pkg;

    localparam int DESC_BYTES = 8;
    localparam logic [2:0] HDR_DDR_MODE = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } hdr_state_e;

    typedef struct packed {
        logic [2:0]  cmd_attr;
        logic [3:0]  tid;
        logic [7:0]  cmd;
        logic        cp;
        logic [4:0]  dev_index;
        logic [2:0]  dtt;
        logic [2:0]  mode;
        logic        rnw;
        logic        wroc;
        logic        toc;
        logic [7:0]  def_byte;
        logic [23:0] data;
    } hdr_desc_t;

endpackage

// File: rtl/hdr_cmd_fetch.sv
// Fetches an 8-byte HDR command descriptor from the register file,
// yielding the port to host config writes, and presents it with valid/ready.
module hdr_cmd_fetch
    import hdr_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst_n,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_cfg_wr_en,
    output logic              o_regf_rd_en,
    output logic [ADDR_W-1:0] o_regf_addr,
    input  logic [7:0]        i_regf_data,
    output logic              o_desc_valid,
    input  logic              i_desc_ready,
    output logic [2:0]        o_cmd_attr,
    output logic [3:0]        o_tid,
    output logic [7:0]        o_cmd,
    output logic              o_cp,
    output logic [4:0]        o_dev_index,
    output logic [2:0]        o_dtt,
    output logic [2:0]        o_mode,
    output logic              o_rnw,
    output logic              o_wroc,
    output logic              o_toc,
    output logic [7:0]        o_def_byte,
    output logic [23:0]       o_data,
    output logic              o_busy,
    output logic              o_desc_err
);

    localparam logic [3:0] LAST_SLOT = 4'(DESC_BYTES - 1);
    localparam logic [3:0] NUM_BYTES = 4'(DESC_BYTES);

    hdr_state_e        state_q;
    logic [ADDR_W-1:0] base_q;
    logic [3:0]        issue_q;
    logic [3:0]        cap_q;
    logic              pend_q;
    logic [7:0]        byte_q [0:DESC_BYTES-2];
    hdr_desc_t         desc_q;
    hdr_desc_t         desc_d;
    logic              err_q;
    logic              err_d;

    logic                    rd_en;
    logic [ADDR_W-1:0]       rd_addr;
    logic [8*DESC_BYTES-1:0] raw;

    // Host config writes own the regfile port; issuing simply pauses.
    assign rd_en   = (state_q == ST_FETCH) && (issue_q < NUM_BYTES)
                   && !i_cfg_wr_en;
    assign rd_addr = base_q + ADDR_W'(issue_q);

    assign o_regf_rd_en = rd_en;
    assign o_regf_addr  = rd_en ? rd_addr : '0;

    // The last byte is decoded straight from the read bus as it lands.
    always_comb begin
        raw = '0;
        for (int i = 0; i < DESC_BYTES - 1; i++) begin
            raw[i*8 +: 8] = byte_q[i];
        end
        raw[8*DESC_BYTES-1 -: 8] = i_regf_data;
    end

    always_comb begin
        desc_d           = '0;
        desc_d.cmd_attr  = raw[2:0];
        desc_d.tid       = raw[6:3];
        desc_d.cmd       = {raw[14:8], raw[7]};
        desc_d.cp        = raw[15];
        desc_d.dev_index = raw[20:16];
        desc_d.dtt       = {raw[25:24], raw[23]};
        desc_d.mode      = raw[28:26];
        desc_d.rnw       = raw[29];
        desc_d.wroc      = raw[30];
        desc_d.toc       = raw[31];
        desc_d.def_byte  = raw[39:32];
        desc_d.data      = raw[63:40];
        err_d = (raw[22:21] != 2'b00) || (raw[28:26] != HDR_DDR_MODE);
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            issue_q <= '0;
            cap_q   <= '0;
            pend_q  <= 1'b0;
            desc_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DESC_BYTES - 1; i++) begin
                byte_q[i] <= '0;
            end
        end else begin
            pend_q <= rd_en;
            unique case (state_q)
                ST_IDLE: begin
                    if (i_fetch_req) begin
                        base_q  <= i_base_addr;
                        issue_q <= '0;
                        cap_q   <= '0;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (rd_en) begin
                        issue_q <= issue_q + 4'd1;
                    end
                    if (pend_q) begin
                        cap_q <= cap_q + 4'd1;
                        if (cap_q == LAST_SLOT) begin
                            desc_q  <= desc_d;
                            err_q   <= err_d;
                            state_q <= ST_VALID;
                        end else begin
                            byte_q[cap_q[2:0]] <= i_regf_data;
                        end
                    end
                end
                ST_VALID: begin
                    if (i_desc_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_busy       = (state_q != ST_IDLE);
    assign o_desc_valid = (state_q == ST_VALID);
    assign o_desc_err   = err_q;

    assign o_cmd_attr  = desc_q.cmd_attr;
    assign o_tid       = desc_q.tid;
    assign o_cmd       = desc_q.cmd;
    assign o_cp        = desc_q.cp;
    assign o_dev_index = desc_q.dev_index;
    assign o_dtt       = desc_q.dtt;
    assign o_mode      = desc_q.mode;
    assign o_rnw       = desc_q.rnw;
    assign o_wroc      = desc_q.wroc;
    assign o_toc       = desc_q.toc;
    assign o_def_byte  = desc_q.def_byte;
    assign o_data      = desc_q.data;

endmodule

// File: doc/hdr_cmd_fetch.md
HDR_CMD_FETCH -- requirements
Module: hdr_cmd_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: register-file address width.
REQ-002 SHALL have port i_sys_clk, input, 1: system clock; all flops rise-edge.
REQ-003 SHALL have port i_sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port i_fetch_req, input, 1: start descriptor fetch; sampled in IDLE only.
REQ-005 SHALL have port i_base_addr, input, ADDR_W: descriptor base address; captured with i_fetch_req.
REQ-006 SHALL have port i_cfg_wr_en, input, 1: host config write owns the regfile port this cycle (priority).
REQ-007 SHALL have port o_regf_rd_en, output, 1: regfile read strobe.
REQ-008 SHALL have port o_regf_addr, output, ADDR_W: regfile read address.
REQ-009 SHALL have port i_regf_data, input, 8: regfile read data, valid one cycle after a read.
REQ-010 SHALL have port o_desc_valid, output, 1: assembled descriptor valid.
REQ-011 SHALL have port i_desc_ready, input, 1: HDR engine accepts descriptor.
REQ-012 SHALL have descriptor output fields: o_cmd_attr 3, o_tid 4, o_cmd 8, o_cp 1, o_dev_index 5, o_dtt 3, o_mode 3, o_rnw 1, o_wroc 1, o_toc 1, o_def_byte 8, o_data 24.
REQ-013 SHALL have port o_busy, output, 1: state is not IDLE.
REQ-014 SHALL have port o_desc_err, output, 1: byte2[6:5] reserved bits nonzero or o_mode != 3'd6.

Function
REQ-015 SHALL implement FSM IDLE -> FETCH -> VALID -> IDLE.
REQ-016 IDLE: i_fetch_req=1 at a rising edge SHALL capture i_base_addr, clear the issue and capture counters, and enter FETCH.
REQ-017 FETCH: each cycle with issue count < 8 and i_cfg_wr_en=0 SHALL drive o_regf_rd_en=1 and o_regf_addr = base + issue count, then increment the issue count.
REQ-018 When i_cfg_wr_en=1, o_regf_rd_en SHALL be 0 and the issue count SHALL hold; a read issued in the previous cycle SHALL still be captured.
REQ-019 The byte from the read issued in cycle N SHALL be captured from i_regf_data at the end of cycle N+1 into byte slot equal to the capture count; the capture count then increments.
REQ-020 Address arithmetic SHALL wrap modulo 2^ADDR_W (base 0xFFE reads 0xFFE, 0xFFF, 0x000, ... 0x005).
REQ-021 When the 8th byte is captured, the FSM SHALL enter VALID; with no stalls, o_desc_valid SHALL rise on the 9th rising edge after the edge sampling i_fetch_req.
REQ-022 Byte mapping: b0 = {cmd[0], tid[3:0], cmd_attr[2:0]}; b1 = {cp, cmd[7:1]}; b2 = {dtt[0], rsvd[1:0], dev_index[4:0]}; b3 = {toc, wroc, rnw, mode[2:0], dtt[2:1]}; b4 = def_byte; o_data = {b7, b6, b5}.
REQ-023 Field outputs and o_desc_err SHALL be registered and held stable while o_desc_valid=1, and retained after handshake until the next fetch completes.
REQ-024 VALID: o_desc_valid=1 until a rising edge with i_desc_ready=1, then IDLE; i_fetch_req outside IDLE, including the same cycle as the handshake, SHALL be ignored.
REQ-025 o_desc_err SHALL be informational only; the descriptor is still delivered.
REQ-026 o_regf_rd_en SHALL be 0 in IDLE and VALID.

Reset
REQ-027 While i_sys_rst_n=0, the FSM SHALL enter IDLE, clear counters and base, and drive every output to 0, including mid-FETCH and during VALID.
REQ-028 After reset release, a new fetch SHALL require a fresh i_fetch_req; no partial descriptor SHALL be presented.

Structure
REQ-029 Shared package hdr_pkg SHALL hold the FSM state enum, DESC_BYTES=8, a packed descriptor struct with the REQ-022 field widths, and HDR_DDR_MODE=3'd6.
REQ-030 No sub-module SHALL be used; counters, FSM and byte assembly are inline.

Verification
REQ-031 Base 1000, regfile 1000..1007 = 18,00,03,99,01,02,03,04 hex, no stalls -> reads at addr 1000..1007 on 8 consecutive cycles; valid after 9 edges; tid=3, cmd=0, cmd_attr=0, cp=0, dev_index=3, dtt=2, mode=6, rnw=0, wroc=0, toc=1, def_byte=1, o_data=0x040302, o_desc_err=0.
REQ-032 Same data, i_cfg_wr_en=1 for 3 cycles after the 2nd read -> no rd_en during those cycles; byte1 still captured; valid after 12 edges; fields identical to REQ-031.
REQ-033 Base 0xFFE -> addresses FFE, FFF, 000..005; descriptor assembled from those locations in order.
REQ-034 i_desc_ready held 0 for 20 cycles, then i_fetch_req pulsed in VALID -> valid and fields stable throughout, request ignored; ready=1 -> IDLE next edge, o_busy=0.
REQ-035 Reset asserted after the 4th read -> all outputs 0 immediately; after release, a new request fetches cleanly with a byte2 reserved field of 2'b01 -> o_desc_err=1.
